brightness_stream_ctrl: RTL and testbench
=========================================

// Module: brightness_stream_ctrl
// PURPOSE
//  Sequencer for brightness_processor. On start: reads cfg_len words from source
//  memory, streams them through the processor, buffers results in an output FIFO,
//  writes them to destination memory. Sits between the host config regs and the
//  pixel memories; the only block that drives the processor's vld/last_data/mode.
// PARAMETERS
//  DATA_WIDTH  32  pixel word width (32 or 64), matches brightness_processor
//  ADDR_WIDTH  16  word address / length width for both memories
//  FIFO_DEPTH  4   output FIFO entries; >=3 legal, >=4 required for 1 word/clk
// PORTS
//  clk             in   1           clock
//  rst_n           in   1           async active-low reset
//  start           in   1           1-clk pulse, accepted only in IDLE
//  cfg_mode        in   2           processor mode, latched on start
//  cfg_proc_val    in   8           threshold/brightness value, latched on start
//  cfg_src_addr    in   ADDR_WIDTH  first source word address
//  cfg_dst_addr    in   ADDR_WIDTH  first destination word address
//  cfg_len         in   ADDR_WIDTH  word count; 0 = empty job
//  busy            out  1           high in every state except IDLE
//  done            out  1           1-clk pulse, job complete
//  err             out  1           1-clk pulse, start received while busy
//  rd_en/rd_addr   out  1/ADDR_W    source read; rd_data valid the next clk
//  rd_data         in   DATA_WIDTH  source read data
//  bp_vld/bp_last  out  1/1         processor vld / last_data
//  bp_mode         out  2           processor mode (latched cfg_mode)
//  bp_proc_val     out  8           processor proc_val (latched)
//  bp_data         out  DATA_WIDTH  processor data_in (= rd_data)
//  bp_data_out     in   DATA_WIDTH  processor result
//  bp_data_out_vld in   1           processor result valid (1 clk after bp_vld)
//  wr_en/wr_addr   out  1/ADDR_W    destination write request / address
//  wr_data         out  DATA_WIDTH  FIFO head
//  wr_rdy          in   1           write accepted when wr_en && wr_rdy
// BEHAVIOUR
//  Reset: state=IDLE; all counters/FIFO cleared; every output 0.
//  FSM: IDLE -start,len!=0-> RUN; IDLE -start,len==0-> FIN; RUN -issued==len-> DRAIN;
//   DRAIN -written==len-> FIN; FIN -> IDLE (1 clk). done=1 exactly in FIN.
//  start in non-IDLE: ignored, err=1 next clk, latched config unchanged.
//  Issue (RUN): rd_en=1 iff issued<len && fifo_cnt+inflight<FIFO_DEPTH;
//   inflight = rd_pending + proc stage (0..2). rd_addr=src+issued, mod 2^ADDR_WIDTH.
//  rd_pending <= rd_en. bp_vld=rd_pending; bp_data=rd_data (comb);
//   bp_last=rd_pending && word is index len-1.
//  bp_data_out_vld pushes bp_data_out into FIFO. Credit rule makes overflow
//   impossible; push while full is an assertion failure.
//  wr_en=!fifo_empty; pop on wr_en&&wr_rdy; wr_addr=dst+written, mod 2^ADDR_WIDTH;
//   wr_data stable while wr_en && !wr_rdy. Simultaneous push+pop: count unchanged.
//  Latency: start accepted at edge 0 -> rd_en clk1, bp_vld clk2, result clk3,
//   first wr_en clk4. Throughput 1 word/clk with wr_rdy=1.
//  Order preserved: k-th word read goes to dst+k.
//  Reset mid-job: immediate abort, outputs 0, no done; next start works normally.
// TESTING
//  len=4,src=0x10,dst=0x80,mode=2,val=0x10,wr_rdy=1, word0=0xF8201000 ->
//   wr 0xFF302010 @0x80 at clk4; 4 writes back-to-back; done one clk after last write.
//  len=8, wr_rdy=0 -> exactly FIFO_DEPTH rd_en then stall, no overflow; release
//   wr_rdy -> all 8 written in order to dst..dst+7, then done.
//  len=0 start -> done next clk, no rd_en/wr_en/bp_vld ever asserted.
//  start pulsed mid-job with new cfg -> err 1-clk pulse, job finishes with old cfg.
//  src=0xFFFE,len=4 -> rd_addr 0xFFFE,0xFFFF,0x0000,0x0001; bp_last only with 4th.
//  rst_n low at clk6 of len=16 job -> outputs 0 at once; later len=2 job completes.

Source files
------------

// File: rtl/brightness_stream_ctrl.sv
`default_nettype none
// brightness_stream_ctrl: reads a job from source memory, streams it through the
// brightness processor and writes the results to destination memory via an output FIFO.
module brightness_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_proc_val,
  input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  bp_vld,
  output logic                  bp_last,
  output logic [1:0]            bp_mode,
  output logic [7:0]            bp_proc_val,
  output logic [DATA_WIDTH-1:0] bp_data,
  input  logic [DATA_WIDTH-1:0] bp_data_out,
  input  logic                  bp_data_out_vld,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_rdy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              mode_q;
  logic [7:0]              val_q;
  logic [ADDR_WIDTH-1:0]   src_q, dst_q, len_q;
  logic [ADDR_WIDTH-1:0]   issued_q, written_q, written_d;
  logic                    rd_pending_q, proc_q, err_q;
  logic [DATA_WIDTH-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    w_accept, w_push, w_pop, w_fifo_empty, w_fifo_full, w_rd_en;
  logic [CNT_W:0]          w_credit_used;

  assign w_accept     = (state_q == S_IDLE) && start;
  assign w_fifo_empty = (cnt_q == '0);
  assign w_fifo_full  = ({1'b0, cnt_q} == DEPTH_C);
  assign w_push       = bp_data_out_vld;
  assign w_pop        = !w_fifo_empty && wr_rdy;
  assign written_d    = written_q + ADDR_WIDTH'(w_pop);

  // Words already read but not yet in the FIFO still own a FIFO slot.
  assign w_credit_used = {1'b0, cnt_q} + {{CNT_W{1'b0}}, rd_pending_q} + {{CNT_W{1'b0}}, proc_q};

  always_comb begin
    state_d = state_q;
    w_rd_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (cfg_len == '0) ? S_FIN : S_RUN;
      end
      S_RUN: begin
        w_rd_en = (issued_q < len_q) && (w_credit_used < DEPTH_C);
        if (issued_q == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (written_d == len_q) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= '0;
      val_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      written_q    <= '0;
      rd_pending_q <= 1'b0;
      proc_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= w_rd_en;
      proc_q       <= rd_pending_q;
      err_q        <= start && (state_q != S_IDLE);
      if (w_accept) begin
        mode_q    <= cfg_mode;
        val_q     <= cfg_proc_val;
        src_q     <= cfg_src_addr;
        dst_q     <= cfg_dst_addr;
        len_q     <= cfg_len;
        issued_q  <= '0;
        written_q <= '0;
      end else begin
        if (w_rd_en) issued_q <= issued_q + 1'b1;
        written_q <= written_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (w_push) begin
        fifo_q[wptr_q] <= bp_data_out;
        wptr_q         <= (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
      end
      if (w_pop) rptr_q <= (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
      if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_fifo_full));

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign rd_en       = w_rd_en;
  assign rd_addr     = w_rd_en ? (src_q + issued_q) : '0;
  assign bp_vld      = rd_pending_q;
  // The pending word has index issued_q-1, so it is the last one once issued_q reaches len.
  assign bp_last     = rd_pending_q && (issued_q == len_q);
  assign bp_mode     = mode_q;
  assign bp_proc_val = val_q;
  assign bp_data     = rd_pending_q ? rd_data : '0;
  assign wr_en       = !w_fifo_empty;
  assign wr_addr     = wr_en ? (dst_q + written_q) : '0;
  assign wr_data     = wr_en ? fifo_q[rptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_brightness_stream_ctrl.sv
`default_nettype none
// Directed bench for brightness_stream_ctrl with behavioural source memory and processor stand-ins.
module tb_brightness_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_proc_val = '0;
  logic [15:0] cfg_src_addr = '0, cfg_dst_addr = '0, cfg_len = '0;
  logic        busy, done, err, rd_en, bp_vld, bp_last, wr_en;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] rd_data = '0, bp_data, bp_data_out, wr_data;
  logic [1:0]  bp_mode;
  logic [7:0]  bp_proc_val;
  logic        bp_data_out_vld;
  logic        wr_rdy = 1'b1;

  brightness_stream_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_proc_val(cfg_proc_val),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .bp_vld(bp_vld), .bp_last(bp_last), .bp_mode(bp_mode), .bp_proc_val(bp_proc_val),
    .bp_data(bp_data), .bp_data_out(bp_data_out), .bp_data_out_vld(bp_data_out_vld),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;

  logic [31:0] src_mem [0:65535];

  // Mode 2 is a per-byte saturating brightness add; other modes pass data through.
  function automatic logic [31:0] proc_fn(input logic [1:0] m, input logic [7:0] v, input logic [31:0] d);
    logic [31:0] r;
    logic [8:0]  s;
    r = d;
    if (m == 2'd2) begin
      for (int i = 0; i < 4; i++) begin
        s = {1'b0, d[8*i +: 8]} + {1'b0, v};
        r[8*i +: 8] = s[8] ? 8'hFF : s[7:0];
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_data_out_vld <= 1'b0;
      bp_data_out     <= '0;
    end else begin
      bp_data_out_vld <= bp_vld;
      bp_data_out     <= proc_fn(bp_mode, bp_proc_val, bp_data);
    end
  end

  int          rd_cyc_q[$], bpv_cyc_q[$], bpl_cyc_q[$], wr_cyc_q[$], done_cyc_q[$];
  logic [15:0] rd_addr_q[$], wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_en_cnt = 0, err_cnt = 0, stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin rd_cyc_q.push_back(cyc); rd_addr_q.push_back(rd_addr); end
      if (bp_vld) bpv_cyc_q.push_back(cyc);
      if (bp_last) bpl_cyc_q.push_back(cyc);
      if (wr_en) wr_en_cnt++;
      if (wr_en && wr_rdy) begin
        wr_cyc_q.push_back(cyc); wr_addr_q.push_back(wr_addr); wr_data_q.push_back(wr_data);
      end
      if (wr_en && prev_stall && (wr_data !== prev_data)) stab_viol++;
      if (done) done_cyc_q.push_back(cyc);
      if (err) err_cnt++;
      prev_stall = wr_en && !wr_rdy;
      prev_data  = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    rd_cyc_q.delete(); bpv_cyc_q.delete(); bpl_cyc_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    wr_en_cnt = 0; err_cnt = 0; stab_viol = 0;
  endtask

  // Leaves the caller in clk1; t0 is the index of the accepting edge so clk k sees cyc == t0+k.
  task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                           input logic [1:0] m, input logic [7:0] v);
    cfg_src_addr = s; cfg_dst_addr = d; cfg_len = l; cfg_mode = m; cfg_proc_val = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done_cyc_q.size() > 0) begin timed_out = 1'b0; break; end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    logic any_out;
    rst_n = 1'b0;
    tick(); tick();
    any_out = busy | done | err | rd_en | bp_vld | bp_last | wr_en | (|rd_addr) | (|wr_addr) |
              (|wr_data) | (|bp_data) | (|bp_mode) | (|bp_proc_val);
    n_checks++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: got any=%b want 0", any_out); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit to;
    logic [31:0] exp_d [4];
    exp_d = '{32'hFF302010, 32'h10101010, 32'hFFFFFFFF, 32'h22FF4466};
    src_mem[16'h10] = 32'hF8201000; src_mem[16'h11] = 32'h00000000;
    src_mem[16'h12] = 32'hFFFFFFFF; src_mem[16'h13] = 32'h12EF3456;
    clear_logs(); wr_rdy = 1'b1;
    start_job(16'h0010, 16'h0080, 16'd4, 2'd2, 8'h10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_done(to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got timeout=%b want 0", to); end
    n_checks++;
    if (rd_cyc_q[0] !== t0 + 1) begin n_fail++; $display("FAIL basic_rd_lat: got clk%0d want clk1", rd_cyc_q[0] - t0); end
    n_checks++;
    if (bpv_cyc_q[0] !== t0 + 2) begin n_fail++; $display("FAIL basic_vld_lat: got clk%0d want clk2", bpv_cyc_q[0] - t0); end
    n_checks++;
    if (wr_cyc_q.size() !== 4) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 4", wr_cyc_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_cyc_q[k] !== t0 + 4 + k || wr_addr_q[k] !== 16'h0080 + 16'(k) || wr_data_q[k] !== exp_d[k]) begin
        n_fail++;
        $display("FAIL basic_wr%0d: got clk%0d @%h=%h want clk%0d @%h=%h", k, wr_cyc_q[k] - t0,
                 wr_addr_q[k], wr_data_q[k], 4 + k, 16'h0080 + 16'(k), exp_d[k]);
      end
    end
    n_checks++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== wr_cyc_q[3] + 1) begin
      n_fail++; $display("FAIL basic_done: got n=%0d clk%0d want n=1 clk%0d", done_cyc_q.size(), done_cyc_q[0] - t0, wr_cyc_q[3] + 1 - t0);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs(); wr_rdy = 1'b0;
    start_job(16'h0200, 16'h0300, 16'd8, 2'd2, 8'h00);
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (rd_cyc_q.size() !== 4) begin n_fail++; $display("FAIL bp_stall_reads: got %0d want 4", rd_cyc_q.size()); end
    n_checks++;
    if (wr_cyc_q.size() !== 0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_state: got wr=%0d busy=%b want 0/1", wr_cyc_q.size(), busy); end
    wr_rdy = 1'b1;
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || wr_cyc_q.size() !== 8) begin n_fail++; $display("FAIL bp_complete: got timeout=%b wr=%0d want 0/8", to, wr_cyc_q.size()); end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (wr_addr_q[k] !== 16'h0300 + 16'(k) || wr_data_q[k] !== src_mem[16'h0200 + k]) begin
        n_fail++; $display("FAIL bp_wr%0d: got @%h=%h want @%h=%h", k, wr_addr_q[k], wr_data_q[k], 16'h0300 + 16'(k), src_mem[16'h0200 + k]);
      end
    end
    n_checks++;
    if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_wr_data_stable: got %0d changes want 0", stab_viol); end
  endtask

  task automatic test_len0();
    clear_logs();
    start_job(16'h0050, 16'h0060, 16'd0, 2'd2, 8'h00);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL len0_done: got %b want 1", done); end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL len0_idle: got done=%b busy=%b want 0/0", done, busy); end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (rd_cyc_q.size() !== 0 || bpv_cyc_q.size() !== 0 || wr_en_cnt !== 0 || done_cyc_q.size() !== 1) begin
      n_fail++; $display("FAIL len0_activity: got rd=%0d vld=%0d wr=%0d done=%0d want 0/0/0/1",
                         rd_cyc_q.size(), bpv_cyc_q.size(), wr_en_cnt, done_cyc_q.size());
    end
  endtask

  task automatic test_err();
    bit to;
    clear_logs(); wr_rdy = 1'b1;
    start_job(16'h0400, 16'h0500, 16'd6, 2'd2, 8'h01);
    tick(); tick();
    cfg_mode = 2'd1; cfg_proc_val = 8'h55; cfg_src_addr = 16'h0999; cfg_dst_addr = 16'h0999; cfg_len = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b want 1", err); end
    n_checks++;
    if (bp_mode !== 2'd2 || bp_proc_val !== 8'h01) begin n_fail++; $display("FAIL err_cfg_kept: got mode=%0d val=%h want 2/01", bp_mode, bp_proc_val); end
    tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_one_clk: got %b want 0", err); end
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || wr_cyc_q.size() !== 6 || err_cnt !== 1) begin
      n_fail++; $display("FAIL err_job: got timeout=%b wr=%0d errs=%0d want 0/6/1", to, wr_cyc_q.size(), err_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (wr_addr_q[k] !== 16'h0500 + 16'(k) || wr_data_q[k] !== proc_fn(2'd2, 8'h01, src_mem[16'h0400 + k])) begin
        n_fail++; $display("FAIL err_wr%0d: got @%h=%h want @%h=%h", k, wr_addr_q[k], wr_data_q[k],
                           16'h0500 + 16'(k), proc_fn(2'd2, 8'h01, src_mem[16'h0400 + k]));
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    logic [15:0] exp_a [4];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    clear_logs(); wr_rdy = 1'b1;
    start_job(16'hFFFE, 16'h0010, 16'd4, 2'd2, 8'h00);
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || rd_addr_q.size() !== 4) begin n_fail++; $display("FAIL wrap_reads: got timeout=%b rd=%0d want 0/4", to, rd_addr_q.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rd_addr_q[k] !== exp_a[k] || wr_data_q[k] !== src_mem[exp_a[k]]) begin
        n_fail++; $display("FAIL wrap_rd%0d: got @%h data=%h want @%h data=%h", k, rd_addr_q[k], wr_data_q[k], exp_a[k], src_mem[exp_a[k]]);
      end
    end
    n_checks++;
    if (bpl_cyc_q.size() !== 1 || bpl_cyc_q[0] !== bpv_cyc_q[3]) begin
      n_fail++; $display("FAIL wrap_last: got n=%0d clk%0d want n=1 clk%0d", bpl_cyc_q.size(), bpl_cyc_q[0] - t0, bpv_cyc_q[3] - t0);
    end
  endtask

  task automatic test_reset_mid_job();
    bit to;
    logic any_out;
    clear_logs(); wr_rdy = 1'b1;
    start_job(16'h0020, 16'h0600, 16'd16, 2'd2, 8'h00);
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wr_en !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_active: got wr_en=%b busy=%b want 1/1", wr_en, busy); end
    #1 rst_n = 1'b0;
    #1;
    any_out = busy | done | err | rd_en | bp_vld | bp_last | wr_en | (|rd_addr) | (|wr_addr) |
              (|wr_data) | (|bp_data) | (|bp_mode) | (|bp_proc_val);
    n_checks++;
    if (any_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got any=%b want 0", any_out); end
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (done_cyc_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got done=%0d busy=%b want 0/0", done_cyc_q.size(), busy); end
    clear_logs();
    start_job(16'h0040, 16'h0700, 16'd2, 2'd2, 8'h00);
    wait_done(to);
    n_checks++;
    if (to !== 1'b0 || wr_cyc_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_next_job: got timeout=%b wr=%0d want 0/2", to, wr_cyc_q.size()); end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (wr_addr_q[k] !== 16'h0700 + 16'(k) || wr_data_q[k] !== src_mem[16'h0040 + k]) begin
        n_fail++; $display("FAIL rstmid_wr%0d: got @%h=%h want @%h=%h", k, wr_addr_q[k], wr_data_q[k], 16'h0700 + 16'(k), src_mem[16'h0040 + k]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      src_mem[i] = {8'(i), 8'(i >> 8), 8'h3C, 8'(i * 3)};
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_err();
    test_wrap();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
